// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - store funct3 encodings, queue entry type and access-size decode
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  localparam int XLEN_MAX   = 64;
  localparam int NBYTES_MAX = XLEN_MAX / 8;

  // Fields are sized for the widest legal XLEN; narrower builds zero-extend into them.
  typedef struct packed {
    logic [XLEN_MAX-1:0]   addr;
    logic [XLEN_MAX-1:0]   data;
    logic [NBYTES_MAX-1:0] bmask;
  } sb_entry_t;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_SB:   size_bytes = 4'd1;
      F3_SH:   size_bytes = 4'd2;
      F3_SW:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_fmt.sv
// rtl/store_lane_fmt.sv - combinational byte-lane formatting of one store into one or two entries
// STORE_MISALIGN_SPLIT_EN: word-crossing stores become a low/high entry pair instead of an error.
module store_lane_fmt
  import store_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_st_data,
  input  logic [2:0]      i_funct3,
  output sb_entry_t       o_lo,
  output sb_entry_t       o_hi,
  output logic            o_split,
  output logic            o_err
);

  localparam int NBYTES = XLEN / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int MW     = 2 * NBYTES;

  logic [LSB-1:0]    w_lane;
  logic [3:0]        w_size;
  logic              w_legal;
  logic [MW-1:0]     w_mask_base;
  logic [MW-1:0]     w_mask_sh;
  logic [2*XLEN-1:0] w_data_sh;
  logic [2*XLEN-1:0] w_data_m;
  logic [XLEN-1:0]   w_base;

  assign w_lane      = i_addr[LSB-1:0];
  assign w_size      = size_bytes(i_funct3);
  assign w_legal     = !i_funct3[2] && ((i_funct3 != F3_SD) || (XLEN == 64));
  assign w_mask_base = (MW'(1) << w_size) - MW'(1);
  // Shift across a double-width window: the upper half is what spills into the next word.
  assign w_mask_sh   = w_mask_base << w_lane;
  assign w_data_sh   = {{XLEN{1'b0}}, i_st_data} << {w_lane, 3'b000};
  assign w_base      = {i_addr[XLEN-1:LSB], {LSB{1'b0}}};

  always_comb begin
    w_data_m = '0;
    for (int i = 0; i < MW; i++) begin
      if (w_mask_sh[i]) w_data_m[8*i +: 8] = w_data_sh[8*i +: 8];
    end
  end

  always_comb begin
    o_lo       = '0;
    o_hi       = '0;
    o_lo.addr  = XLEN_MAX'(w_base);
    o_lo.data  = XLEN_MAX'(w_data_m[XLEN-1:0]);
    o_lo.bmask = NBYTES_MAX'(w_mask_sh[NBYTES-1:0]);
    o_hi.addr  = XLEN_MAX'(w_base + XLEN'(NBYTES));
    o_hi.data  = XLEN_MAX'(w_data_m[2*XLEN-1:XLEN]);
    o_hi.bmask = NBYTES_MAX'(w_mask_sh[MW-1:NBYTES]);
  end

`ifdef STORE_MISALIGN_SPLIT_EN
  assign o_split = w_legal && (w_mask_sh[MW-1:NBYTES] != '0);
  assign o_err   = !w_legal;
`else
  logic [LSB-1:0] w_misal;
  assign w_misal = w_lane & LSB'(w_size - 4'd1);
  assign o_split = 1'b0;
  assign o_err   = !w_legal || (w_misal != '0);
`endif

endmodule

// File: rtl/store_buffer_unit.sv
// rtl/store_buffer_unit.sv - store queue: formats accepted stores, presents the registered FIFO head to memory
// STORE_MISALIGN_SPLIT_EN: two free entries are required per request so a split pair always fits.
module store_buffer_unit
  import store_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [XLEN-1:0]          i_addr,
  input  logic [XLEN-1:0]          i_st_data,
  input  logic [2:0]               i_funct3,
  output logic                     o_mem_valid,
  input  logic                     i_mem_ready,
  output logic [XLEN-1:0]          o_mem_addr,
  output logic [XLEN-1:0]          o_mem_data,
  output logic [XLEN/8-1:0]        o_mem_bmask,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_err
);

  localparam int NBYTES = XLEN / 8;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
`ifdef STORE_MISALIGN_SPLIT_EN
  localparam int NEED = 2;
`else
  localparam int NEED = 1;
`endif

  sb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic            r_err;

  sb_entry_t       w_lo;
  sb_entry_t       w_hi;
  logic            w_split;
  logic            w_fmt_err;
  logic            w_accept;
  logic            w_deq;
  logic [CW-1:0]   w_free;
  logic [CW-1:0]   w_nenq;

  store_lane_fmt #(.XLEN(XLEN)) u_fmt (
    .i_addr    (i_addr),
    .i_st_data (i_st_data),
    .i_funct3  (i_funct3),
    .o_lo      (w_lo),
    .o_hi      (w_hi),
    .o_split   (w_split),
    .o_err     (w_fmt_err)
  );

  assign w_free      = CW'(DEPTH) - r_count;
  assign o_req_ready = i_rst_n && (w_free >= CW'(NEED));
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_deq       = o_mem_valid && i_mem_ready;

  always_comb begin
    w_nenq = '0;
    if (w_accept && !w_fmt_err) w_nenq = w_split ? CW'(2) : CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wr    <= r_wr + PW'(w_nenq);
      r_rd    <= r_rd + PW'(w_deq);
      r_count <= r_count + w_nenq - CW'(w_deq);
      r_err   <= w_accept && w_fmt_err;
    end
  end

  // Entry storage needs no reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && (w_nenq != '0)) begin
      r_mem[r_wr] <= w_lo;
      if (w_nenq == CW'(2)) r_mem[r_wr + PW'(1)] <= w_hi;
    end
  end

  assign o_mem_addr  = r_mem[r_rd].addr[XLEN-1:0];
  assign o_mem_data  = r_mem[r_rd].data[XLEN-1:0];
  assign o_mem_bmask = r_mem[r_rd].bmask[NBYTES-1:0];
  assign o_count     = r_count;
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_mem_valid = !o_empty;
  assign o_err       = r_err;

endmodule

// File: tb/tb_store_buffer_unit.sv
// tb/tb_store_buffer_unit.sv - directed and randomized store buffer bench against a byte-level queue model
`timescale 1ns/1ps
module tb_store_buffer_unit;

  localparam int DEPTH = 4;
`ifdef STORE_MISALIGN_SPLIT_EN
  localparam int NEED = 2;
`else
  localparam int NEED = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_ready, mem_valid, mem_ready;
  logic [31:0] addr, st_data, mem_addr, mem_data;
  logic [2:0]  funct3;
  logic [3:0]  mem_bmask;
  logic [2:0]  count;
  logic        empty, full, err;

  logic        d_rst_n, d_valid, d_ready, d_mvalid, d_mrdy;
  logic [63:0] d_addr, d_data, d_maddr, d_mdata;
  logic [2:0]  d_f3, d_count;
  logic [7:0]  d_bmask;
  logic        d_empty, d_full, d_err;

  store_buffer_unit #(.XLEN(32), .DEPTH(DEPTH)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_addr(addr), .i_st_data(st_data), .i_funct3(funct3), .o_mem_valid(mem_valid),
    .i_mem_ready(mem_ready), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
    .o_mem_bmask(mem_bmask), .o_count(count), .o_empty(empty), .o_full(full), .o_err(err)
  );

  store_buffer_unit #(.XLEN(64), .DEPTH(DEPTH)) u_dut64 (
    .i_clk(clk), .i_rst_n(d_rst_n), .i_req_valid(d_valid), .o_req_ready(d_ready),
    .i_addr(d_addr), .i_st_data(d_data), .i_funct3(d_f3), .o_mem_valid(d_mvalid),
    .i_mem_ready(d_mrdy), .o_mem_addr(d_maddr), .o_mem_data(d_mdata),
    .o_mem_bmask(d_bmask), .o_count(d_count), .o_empty(d_empty), .o_full(d_full), .o_err(d_err)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } exp_t;

  exp_t q[$];
  bit   exp_err;
  int   n_checks;
  int   n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte-by-byte placement: each byte lands in the word holding its own address.
  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int   sz;
    bit   bad;
    bit   two;
    exp_t e0;
    exp_t e1;
    sz  = 1 << f3[1:0];
    bad = f3[2] || (f3[1:0] == 2'd3);
`ifndef STORE_MISALIGN_SPLIT_EN
    if ((a % sz) != 0) bad = 1'b1;
`endif
    if (bad) begin
      exp_err = 1'b1;
      return;
    end
    two  = 1'b0;
    e0.a = a - (a % 4);
    e0.d = '0;
    e0.m = '0;
    e1.a = e0.a + 32'd4;
    e1.d = '0;
    e1.m = '0;
    for (int k = 0; k < sz; k++) begin
      logic [31:0] ba;
      int          ln;
      ba = a + k;
      ln = ba % 4;
      if ((ba >> 2) == (a >> 2)) begin
        e0.d[8*ln +: 8] = d[8*k +: 8];
        e0.m[ln]        = 1'b1;
      end else begin
        two             = 1'b1;
        e1.d[8*ln +: 8] = d[8*k +: 8];
        e1.m[ln]        = 1'b1;
      end
    end
    q.push_back(e0);
    if (two) q.push_back(e1);
  endtask

  task automatic step(input bit in_rst_n, input bit in_valid, input logic [31:0] in_addr,
                      input logic [31:0] in_data, input logic [2:0] in_f3, input bit in_mrdy);
    bit exp_rdy;
    rst_n     = in_rst_n;
    req_valid = in_valid;
    addr      = in_addr;
    st_data   = in_data;
    funct3    = in_f3;
    mem_ready = in_mrdy;
    #1;
    exp_rdy = in_rst_n && ((DEPTH - q.size()) >= NEED);
    check("req_ready", req_ready, exp_rdy);
    exp_err = 1'b0;
    if (!in_rst_n) begin
      q.delete();
    end else begin
      if ((q.size() > 0) && in_mrdy) void'(q.pop_front());
      if (in_valid && exp_rdy) model_store(in_addr, in_data, in_f3);
    end
    @(posedge clk);
    #1;
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == DEPTH);
    check("mem_valid", mem_valid, q.size() != 0);
    check("err", err, exp_err);
    if (q.size() != 0) begin
      check("head_addr", mem_addr, q[0].a);
      check("head_data", mem_data, q[0].d);
      check("head_bmask", mem_bmask, q[0].m);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; req_valid = 1'b0; addr = '0; st_data = '0; funct3 = '0; mem_ready = 1'b0;
    d_rst_n = 1'b0; d_valid = 1'b0; d_addr = '0; d_data = '0; d_f3 = '0; d_mrdy = 1'b0;
    exp_err = 1'b0;
    @(posedge clk);
    #1;

    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h10, 32'h1, 3'b010, 0);

    step(1, 1, 32'h1003, 32'h0000_00AB, 3'b000, 1);
    check("sb_valid", mem_valid, 1);
    check("sb_addr", mem_addr, 32'h1000);
    check("sb_data", mem_data, 32'hAB00_0000);
    check("sb_bmask", mem_bmask, 4'b1000);
    step(1, 0, 0, 0, 0, 1);

    for (int i = 0; i < 4; i++) step(1, 1, 32'h100 + 4 * i, $urandom, 3'b010, 0);
    check("fill_count", count, (NEED == 1) ? 4 : 3);
    check("fill_full", full, NEED == 1);
    check("fill_ready", req_ready, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1);
    check("drain_empty", empty, 1);

    step(1, 1, 32'h2002, 32'h1122_3344, 3'b010, 0);
`ifdef STORE_MISALIGN_SPLIT_EN
    check("split_count", count, 2);
    check("split_err", err, 0);
    check("split_lo_addr", mem_addr, 32'h2000);
    check("split_lo_data", mem_data, 32'h3344_0000);
    check("split_lo_bmask", mem_bmask, 4'b1100);
    step(1, 0, 0, 0, 0, 1);
    check("split_hi_addr", mem_addr, 32'h2004);
    check("split_hi_data", mem_data, 32'h0000_1122);
    check("split_hi_bmask", mem_bmask, 4'b0011);
    step(1, 0, 0, 0, 0, 1);
`else
    check("cross_err", err, 1);
    check("cross_count", count, 0);
`endif

    step(1, 1, 32'h40, 32'h5, 3'b011, 1);
    check("sd32_err", err, 1);
    check("sd32_count", count, 0);
    step(1, 0, 0, 0, 0, 1);
    check("err_pulse_end", err, 0);

    step(1, 1, 32'h300, 32'hA1, 3'b010, 0);
    step(1, 1, 32'h304, 32'hA2, 3'b010, 0);
    step(1, 1, 32'h308, 32'hA3, 3'b010, 1);
    check("enq_deq_count", count, 2);
    step(1, 1, 32'h30C, 32'hA4, 3'b010, 0);
    check("pre_rst_count", count, 3);
    step(0, 0, 0, 0, 0, 0);
    check("rst_count", count, 0);
    check("rst_valid", mem_valid, 0);
    step(1, 0, 0, 0, 0, 1);
    check("post_rst_valid", mem_valid, 0);

    for (int i = 0; i < 300; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 11);
      if (r < 9) f3 = 3'(r % 3);
      else if (r == 9) f3 = 3'b011;
      else f3 = {1'b1, 2'($urandom_range(0, 3))};
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      step($urandom_range(0, 63) != 0, $urandom_range(0, 9) < 7, a, $urandom, f3,
           $urandom_range(0, 9) < 6);
    end

    d_rst_n = 1'b1;
    d_valid = 1'b1;
    d_addr  = 64'h8;
    d_data  = 64'h0102_0304_0506_0708;
    d_f3    = 3'b011;
    d_mrdy  = 1'b0;
    #1;
    check("d64_empty", d_empty, 1);
    check("d64_ready", d_ready, 1);
    @(posedge clk);
    #1;
    check("d64_sd_valid", d_mvalid, 1);
    check("d64_sd_addr", d_maddr, 64'h8);
    check("d64_sd_data", d_mdata, 64'h0102_0304_0506_0708);
    check("d64_sd_bmask", d_bmask, 8'hFF);
    check("d64_sd_err", d_err, 0);
    d_addr = 64'h14;
    d_data = 64'hAABB_CCDD;
    d_f3   = 3'b010;
    d_mrdy = 1'b1;
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    check("d64_sw_count", d_count, 1);
    check("d64_sw_addr", d_maddr, 64'h10);
    check("d64_sw_data", d_mdata, 64'hAABB_CCDD_0000_0000);
    check("d64_sw_bmask", d_bmask, 8'hF0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
